// File: rtl/id_branch_unit_pkg.sv
// ============================================================================
// Module : rv32i_types
// Brief  : Shared RV32I decode types: opcodes, mux selects, control word.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package rv32i_types;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011,
        op_csr   = 7'b1110011
    } rv32i_opcode;

    typedef enum logic [2:0] {
        beq  = 3'b000,
        bne  = 3'b001,
        blt  = 3'b100,
        bge  = 3'b101,
        bltu = 3'b110,
        bgeu = 3'b111
    } branch_funct3_t;

    typedef enum logic [2:0] {
        alu_add = 3'b000,
        alu_sll = 3'b001,
        alu_sra = 3'b010,
        alu_sub = 3'b011,
        alu_xor = 3'b100,
        alu_srl = 3'b101,
        alu_or  = 3'b110,
        alu_and = 3'b111
    } alu_ops;

    typedef enum logic [1:0] {
        pcmux_pc_plus4 = 2'd0,
        pcmux_alu_out  = 2'd1,
        pcmux_alu_mod2 = 2'd2
    } pcmux_sel_t;

    typedef enum logic {
        alumux1_rs1_out = 1'b0,
        alumux1_pc_out  = 1'b1
    } alumux1_sel_t;

    typedef enum logic [2:0] {
        alumux2_i_imm   = 3'd0,
        alumux2_u_imm   = 3'd1,
        alumux2_b_imm   = 3'd2,
        alumux2_s_imm   = 3'd3,
        alumux2_j_imm   = 3'd4,
        alumux2_rs2_out = 3'd5
    } alumux2_sel_t;

    typedef enum logic {
        cmpmux_rs2_out = 1'b0,
        cmpmux_i_imm   = 1'b1
    } cmpmux_sel_t;

    typedef enum logic [3:0] {
        regfilemux_alu_out  = 4'd0,
        regfilemux_br_en    = 4'd1,
        regfilemux_u_imm    = 4'd2,
        regfilemux_lw       = 4'd3,
        regfilemux_pc_plus4 = 4'd4,
        regfilemux_lb       = 4'd5,
        regfilemux_lbu      = 4'd6,
        regfilemux_lh       = 4'd7,
        regfilemux_lhu      = 4'd8
    } regfilemux_sel_t;

    typedef struct packed {
        rv32i_opcode     opcode;
        alu_ops          aluop;
        branch_funct3_t  cmpop;
        alumux1_sel_t    alumux1_sel;
        alumux2_sel_t    alumux2_sel;
        cmpmux_sel_t     cmpmux_sel;
        regfilemux_sel_t regfilemux_sel;
        pcmux_sel_t      pcmux_sel;
        logic            load_regfile;
        logic            mem_read;
        logic            mem_write;
        logic [3:0]      mem_byte_en;
    } rv32i_control_word;

    // funct3 encodings for loads, stores and the arithmetic group
    localparam logic [2:0] F3_LB   = 3'b000;
    localparam logic [2:0] F3_LH   = 3'b001;
    localparam logic [2:0] F3_LW   = 3'b010;
    localparam logic [2:0] F3_LBU  = 3'b100;
    localparam logic [2:0] F3_LHU  = 3'b101;
    localparam logic [2:0] F3_SB   = 3'b000;
    localparam logic [2:0] F3_SH   = 3'b001;
    localparam logic [2:0] F3_SW   = 3'b010;
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_SR   = 3'b101;

endpackage

`default_nettype wire

// File: rtl/id_branch_unit_cmp.sv
// ============================================================================
// Module : id_cmp
// Brief  : Branch / set-less-than comparator for the decode stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module id_cmp
    import rv32i_types::*;
#(
    parameter int WIDTH = 32
) (
    input  branch_funct3_t   cmpop,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             br_en
);

    always_comb begin
        br_en = 1'b0;
        case (cmpop)
            beq:     br_en = (a == b);
            bne:     br_en = (a != b);
            blt:     br_en = ($signed(a) <  $signed(b));
            bge:     br_en = ($signed(a) >= $signed(b));
            bltu:    br_en = (a <  b);
            bgeu:    br_en = (a >= b);
            default: br_en = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/id_branch_unit.sv
// ============================================================================
// Module : id_branch_unit
// Brief  : ID-stage decode, branch/jump resolution, flush and halt detection.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module id_branch_unit
    import rv32i_types::*;
#(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       instr_i,
    input  logic [WIDTH-1:0]  pc_i,
    input  logic [WIDTH-1:0]  rs1_val_i,
    input  logic [WIDTH-1:0]  rs2_val_i,
    input  logic              bubble_i,
    input  logic              br_pred_i,
    output rv32i_control_word ctrl_o,
    output logic              br_en_o,
    output logic [WIDTH-1:0]  branch_pc_o,
    output pcmux_sel_t        pcmux_sel_o,
    output logic              flush_o,
    output logic              halt_o
);

    rv32i_opcode       opcode;
    logic [2:0]        funct3;
    logic              funct7_5;
    logic [WIDTH-1:0]  i_imm, s_imm, b_imm, u_imm, j_imm;
    rv32i_control_word decoded;
    logic [WIDTH-1:0]  cmp_b;
    logic              br_en;
    logic [WIDTH-1:0]  pc_plus4;
    logic [WIDTH-1:0]  jalr_sum;
    logic              halt_cond;

    assign opcode   = rv32i_opcode'(instr_i[6:0]);
    assign funct3   = instr_i[14:12];
    assign funct7_5 = instr_i[30];

    // Size casts of signed operands sign-extend to the datapath width
    assign i_imm = WIDTH'($signed(instr_i[31:20]));
    assign s_imm = WIDTH'($signed({instr_i[31:25], instr_i[11:7]}));
    assign b_imm = WIDTH'($signed({instr_i[31], instr_i[7], instr_i[30:25],
                                   instr_i[11:8], 1'b0}));
    assign u_imm = WIDTH'($signed({instr_i[31:12], 12'h000}));
    assign j_imm = WIDTH'($signed({instr_i[31], instr_i[19:12], instr_i[20],
                                   instr_i[30:21], 1'b0}));

    always_comb begin
        decoded        = '0;
        decoded.opcode = opcode;
        decoded.aluop  = alu_add;
        case (opcode)
            op_lui: begin
                decoded.load_regfile   = 1'b1;
                decoded.regfilemux_sel = regfilemux_u_imm;
            end
            op_auipc: begin
                decoded.alumux1_sel    = alumux1_pc_out;
                decoded.alumux2_sel    = alumux2_u_imm;
                decoded.regfilemux_sel = regfilemux_alu_out;
                decoded.load_regfile   = 1'b1;
            end
            op_jal: begin
                decoded.alumux1_sel    = alumux1_pc_out;
                decoded.alumux2_sel    = alumux2_j_imm;
                decoded.pcmux_sel      = pcmux_alu_out;
                decoded.regfilemux_sel = regfilemux_pc_plus4;
                decoded.load_regfile   = 1'b1;
            end
            op_jalr: begin
                decoded.alumux1_sel    = alumux1_rs1_out;
                decoded.alumux2_sel    = alumux2_i_imm;
                decoded.pcmux_sel      = pcmux_alu_mod2;
                decoded.regfilemux_sel = regfilemux_pc_plus4;
                decoded.load_regfile   = 1'b1;
            end
            op_br: begin
                decoded.alumux1_sel = alumux1_pc_out;
                decoded.alumux2_sel = alumux2_b_imm;
                decoded.cmpop       = branch_funct3_t'(funct3);
                decoded.cmpmux_sel  = cmpmux_rs2_out;
            end
            op_load: begin
                decoded.alumux1_sel  = alumux1_rs1_out;
                decoded.alumux2_sel  = alumux2_i_imm;
                decoded.mem_read     = 1'b1;
                decoded.load_regfile = 1'b1;
                case (funct3)
                    F3_LB:   decoded.regfilemux_sel = regfilemux_lb;
                    F3_LH:   decoded.regfilemux_sel = regfilemux_lh;
                    F3_LW:   decoded.regfilemux_sel = regfilemux_lw;
                    F3_LBU:  decoded.regfilemux_sel = regfilemux_lbu;
                    F3_LHU:  decoded.regfilemux_sel = regfilemux_lhu;
                    default: decoded.regfilemux_sel = regfilemux_alu_out;
                endcase
            end
            op_store: begin
                decoded.alumux1_sel = alumux1_rs1_out;
                decoded.alumux2_sel = alumux2_s_imm;
                decoded.mem_write   = 1'b1;
                case (funct3)
                    F3_SB:   decoded.mem_byte_en = 4'b0001;
                    F3_SH:   decoded.mem_byte_en = 4'b0011;
                    F3_SW:   decoded.mem_byte_en = 4'b1111;
                    default: decoded.mem_byte_en = 4'b0000;
                endcase
            end
            op_imm: begin
                decoded.alumux2_sel  = alumux2_i_imm;
                decoded.aluop        = alu_ops'(funct3);
                decoded.load_regfile = 1'b1;
                case (funct3)
                    F3_SLT, F3_SLTU: begin
                        decoded.cmpop          = (funct3 == F3_SLT) ? blt : bltu;
                        decoded.cmpmux_sel     = cmpmux_i_imm;
                        decoded.regfilemux_sel = regfilemux_br_en;
                    end
                    F3_SR:   decoded.aluop = funct7_5 ? alu_sra : alu_srl;
                    default: ;
                endcase
            end
            op_reg: begin
                decoded.alumux2_sel  = alumux2_rs2_out;
                decoded.aluop        = alu_ops'(funct3);
                decoded.load_regfile = 1'b1;
                case (funct3)
                    F3_ADD:  decoded.aluop = funct7_5 ? alu_sub : alu_add;
                    F3_SR:   decoded.aluop = funct7_5 ? alu_sra : alu_srl;
                    F3_SLT, F3_SLTU: begin
                        decoded.cmpop          = (funct3 == F3_SLT) ? blt : bltu;
                        decoded.cmpmux_sel     = cmpmux_rs2_out;
                        decoded.regfilemux_sel = regfilemux_br_en;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    // A bubble keeps ALU/compare fields but kills every architectural side effect
    always_comb begin
        ctrl_o = decoded;
        if (bubble_i) begin
            ctrl_o.opcode         = op_csr;
            ctrl_o.load_regfile   = 1'b0;
            ctrl_o.mem_read       = 1'b0;
            ctrl_o.mem_write      = 1'b0;
            ctrl_o.mem_byte_en    = 4'b0000;
            ctrl_o.pcmux_sel      = pcmux_pc_plus4;
            ctrl_o.alumux1_sel    = alumux1_rs1_out;
            ctrl_o.alumux2_sel    = alumux2_rs2_out;
            ctrl_o.regfilemux_sel = regfilemux_alu_out;
        end
    end

    assign cmp_b = (decoded.cmpmux_sel == cmpmux_i_imm) ? i_imm : rs2_val_i;

    id_cmp #(
        .WIDTH (WIDTH)
    ) u_cmp (
        .cmpop (decoded.cmpop),
        .a     (rs1_val_i),
        .b     (cmp_b),
        .br_en (br_en)
    );

    assign br_en_o  = br_en;
    assign pc_plus4 = pc_i + WIDTH'(4);
    assign jalr_sum = rs1_val_i + i_imm;

    always_comb begin
        branch_pc_o = pc_plus4;
        pcmux_sel_o = pcmux_pc_plus4;
        case (decoded.opcode)
            op_br: begin
                if (br_en) begin
                    branch_pc_o = pc_i + b_imm;
                    pcmux_sel_o = pcmux_alu_out;
                end
            end
            op_jal: begin
                branch_pc_o = pc_i + j_imm;
                pcmux_sel_o = pcmux_alu_out;
            end
            op_jalr: begin
                branch_pc_o = {jalr_sum[WIDTH-1:1], 1'b0};
                pcmux_sel_o = pcmux_alu_mod2;
            end
            default: ;
        endcase
    end

    // Uses the post-bubble opcode so a stalled instruction never flushes
    always_comb begin
        flush_o = 1'b0;
        case (ctrl_o.opcode)
            op_br:           flush_o = (br_en != br_pred_i);
            op_jal, op_jalr: flush_o = ~br_pred_i;
            default:         flush_o = 1'b0;
        endcase
    end

    assign halt_cond = (decoded.opcode == op_br) && br_en &&
                       (branch_pc_o == pc_i) && !bubble_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halt_o <= 1'b0;
        end else if (halt_cond) begin
            halt_o <= 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_id_branch_unit.sv
// ============================================================================
// Module : tb_id_branch_unit
// Brief  : Directed self-checking bench for id_branch_unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_id_branch_unit;
    import rv32i_types::*;

    logic              clk;
    logic              rst;
    logic [31:0]       instr;
    logic [31:0]       pc;
    logic [31:0]       rs1_val;
    logic [31:0]       rs2_val;
    logic              bubble;
    logic              br_pred;
    rv32i_control_word ctrl;
    logic              br_en;
    logic [31:0]       branch_pc;
    pcmux_sel_t        pcmux_sel;
    logic              flush;
    logic              halt;

    int pass_cnt  = 0;
    int total_cnt = 0;

    id_branch_unit #(
        .WIDTH (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_i     (instr),
        .pc_i        (pc),
        .rs1_val_i   (rs1_val),
        .rs2_val_i   (rs2_val),
        .bubble_i    (bubble),
        .br_pred_i   (br_pred),
        .ctrl_o      (ctrl),
        .br_en_o     (br_en),
        .branch_pc_o (branch_pc),
        .pcmux_sel_o (pcmux_sel),
        .flush_o     (flush),
        .halt_o      (halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        if (obs === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Apply a vector just after the falling edge and let it settle
    task automatic drive(input logic [31:0] i, input logic [31:0] p,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic bub, input logic pred);
        @(negedge clk);
        instr   = i;
        pc      = p;
        rs1_val = a;
        rs2_val = b;
        bubble  = bub;
        br_pred = pred;
        #1;
    endtask

    initial begin
        rst     = 1'b1;
        instr   = 32'h0000_0013;
        pc      = 32'h0;
        rs1_val = 32'h0;
        rs2_val = 32'h0;
        bubble  = 1'b0;
        br_pred = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_halt", {31'd0, halt}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // beq x1,x2,+8 taken, predicted not-taken
        drive(32'h0020_8463, 32'h100, 32'd5, 32'd5, 1'b0, 1'b0);
        check("beq_br_en",  {31'd0, br_en}, 32'd1);
        check("beq_target", branch_pc, 32'h108);
        check("beq_sel",    32'(pcmux_sel), 32'(pcmux_alu_out));
        check("beq_flush",  {31'd0, flush}, 32'd1);

        // blt / bltu on -1 vs 1
        drive(32'h0020_C463, 32'h100, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1);
        check("blt_br_en",  {31'd0, br_en}, 32'd1);
        check("blt_flush",  {31'd0, flush}, 32'd0);
        drive(32'h0020_E463, 32'h100, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1);
        check("bltu_br_en",  {31'd0, br_en}, 32'd0);
        check("bltu_target", branch_pc, 32'h104);
        check("bltu_sel",    32'(pcmux_sel), 32'(pcmux_pc_plus4));
        check("bltu_flush",  {31'd0, flush}, 32'd1);

        // jalr x1,3(x2) with rs1=0x200: LSB of the sum is cleared
        drive(32'h0031_00E7, 32'h100, 32'h200, 32'd0, 1'b0, 1'b1);
        check("jalr_target", branch_pc, 32'h202);
        check("jalr_sel",    32'(pcmux_sel), 32'(pcmux_alu_mod2));
        check("jalr_flush1", {31'd0, flush}, 32'd0);
        check("jalr_rfmux",  32'(ctrl.regfilemux_sel), 32'(regfilemux_pc_plus4));
        drive(32'h0031_00E7, 32'h100, 32'h200, 32'd0, 1'b0, 1'b0);
        check("jalr_flush0", {31'd0, flush}, 32'd1);

        // Decode of sh / lbu / sub / srai
        drive(32'h0020_9223, 32'h0, 32'd0, 32'd0, 1'b0, 1'b0);
        check("sh_byte_en", {28'd0, ctrl.mem_byte_en}, 32'h3);
        check("sh_mem_wr",  {31'd0, ctrl.mem_write}, 32'd1);
        drive(32'h0000_C183, 32'h0, 32'd0, 32'd0, 1'b0, 1'b0);
        check("lbu_mem_rd", {31'd0, ctrl.mem_read}, 32'd1);
        check("lbu_rfmux",  32'(ctrl.regfilemux_sel), 32'(regfilemux_lbu));
        drive(32'h4020_81B3, 32'h0, 32'd0, 32'd0, 1'b0, 1'b0);
        check("sub_aluop",  32'(ctrl.aluop), 32'(alu_sub));
        drive(32'h4040_D193, 32'h0, 32'd0, 32'd0, 1'b0, 1'b0);
        check("srai_aluop", 32'(ctrl.aluop), 32'(alu_sra));

        // jal +16 under a bubble: no writes, no flush, target still resolved
        drive(32'h0100_00EF, 32'h80, 32'd0, 32'd0, 1'b1, 1'b0);
        check("bub_ldreg",  {31'd0, ctrl.load_regfile}, 32'd0);
        check("bub_opcode", 32'(ctrl.opcode), 32'(op_csr));
        check("bub_flush",  {31'd0, flush}, 32'd0);
        check("bub_target", branch_pc, 32'h90);

        // Bubbled self-loop must not set halt
        drive(32'h0000_0063, 32'h40, 32'd0, 32'd0, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        check("bub_no_halt", {31'd0, halt}, 32'd0);

        // beq x0,x0,0 self-loop sets sticky halt
        drive(32'h0000_0063, 32'h40, 32'd0, 32'd0, 1'b0, 1'b1);
        check("loop_target",   branch_pc, 32'h40);
        check("halt_pre_edge", {31'd0, halt}, 32'd0);
        @(posedge clk);
        #1;
        check("halt_set", {31'd0, halt}, 32'd1);
        drive(32'h0000_0013, 32'h44, 32'd0, 32'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("halt_sticky", {31'd0, halt}, 32'd1);

        // Asynchronous clear away from any clock edge
        #2;
        rst = 1'b1;
        #1;
        check("halt_async_clr", {31'd0, halt}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

`default_nettype wire
